// File: rtl/pu_lut_pkg.sv
// Shared constants for the LUT processing unit: collector FSM state encoding
// and the default position of the invalid flag inside an operand's attribute word.
// Imported by the argument collector and by the LUT output stage.
package pu_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } pu_lut_state_e;

  localparam int PU_LUT_INVALID_IDX = 0;

endpackage : pu_lut_pkg

// File: rtl/pu_lut_arg_collector.sv
// Purpose: collects ARG_COUNT boolean operands (one per i_signal_wr) into a LUT address.
// Latency: o_addr_valid rises the cycle after the last operand write; 1 operand/clk.
// Backpressure: o_addr/o_addr_invalid held while i_addr_ready=0; writes then are dropped and flagged.
// Ports: i_clk/i_rst (sync, active-high); i_signal_wr/i_signal_clr operand strobe and abort;
//        i_data_in/i_attr_in operand word and attributes; o_addr/o_addr_valid/i_addr_ready
//        LUT address handshake; o_addr_invalid OR of operand invalid flags; o_err_overflow sticky.
module pu_lut_arg_collector
  import pu_lut_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int INVALID    = PU_LUT_INVALID_IDX,
  parameter int ADDR_WIDTH = 4,
  parameter int ARG_COUNT  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_signal_wr,
  input  logic                  i_signal_clr,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [ATTR_WIDTH-1:0] i_attr_in,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_addr_valid,
  input  logic                  i_addr_ready,
  output logic                  o_addr_invalid,
  output logic                  o_err_overflow
);

  localparam int IDX_W = $clog2(ARG_COUNT + 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARG_COUNT - 1);
  // After the first operand of an address the FSM is already full when only one operand is needed.
  localparam pu_lut_state_e ST_AFTER_FIRST = (ARG_COUNT == 1) ? ST_FULL : ST_COLLECT;

  pu_lut_state_e         r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
  logic [IDX_W-1:0]      r_idx,   w_idx_nxt;
  logic                  r_inv,   w_inv_nxt;
  logic                  r_err,   w_err_nxt;

  logic w_operand;
  logic w_op_inv;
  logic w_unused_attr;

  assign w_operand     = |i_data_in;
  assign w_op_inv      = i_attr_in[INVALID];
  // Only the invalid bit of the attribute word matters here.
  assign w_unused_attr = ^i_attr_in;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_idx_nxt   = r_idx;
    w_inv_nxt   = r_inv;
    w_err_nxt   = r_err;

    unique case (r_state)
      // IDLE always holds addr=0, idx=0, flag=0, so it shares the collect path:
      // a write there lands in bit 0 exactly like the first write of COLLECT.
      ST_IDLE, ST_COLLECT: begin
        if (i_signal_clr) begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = '0;
          w_idx_nxt   = '0;
          w_inv_nxt   = 1'b0;
        end else if (i_signal_wr) begin
          for (int k = 0; k < ARG_COUNT; k++) begin
            if (r_idx == IDX_W'(k)) begin
              w_addr_nxt[k] = w_operand;
            end
          end
          w_inv_nxt   = r_inv | w_op_inv;
          w_idx_nxt   = r_idx + IDX_ONE;
          w_state_nxt = (r_idx == IDX_LAST) ? ST_FULL : ST_COLLECT;
        end
      end

      // Clear is deliberately ignored here so a finished address is never lost.
      ST_FULL: begin
        if (i_addr_ready) begin
          if (i_signal_wr) begin
            // Back-to-back: the write in the handshake cycle opens the next address.
            w_addr_nxt  = ADDR_WIDTH'(w_operand);
            w_idx_nxt   = IDX_ONE;
            w_inv_nxt   = w_op_inv;
            w_state_nxt = ST_AFTER_FIRST;
          end else begin
            w_addr_nxt  = '0;
            w_idx_nxt   = '0;
            w_inv_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (i_signal_wr) begin
          w_err_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_idx_nxt   = '0;
        w_inv_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_idx   <= '0;
      r_inv   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_idx   <= w_idx_nxt;
      r_inv   <= w_inv_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_addr         = r_addr;
  assign o_addr_valid   = (r_state == ST_FULL);
  assign o_addr_invalid = r_inv;
  assign o_err_overflow = r_err;

endmodule : pu_lut_arg_collector

// File: tb/tb_pu_lut_arg_collector.sv
// Drives one shared stimulus stream into two collectors (4 operands and 1 operand per
// address) and checks both against an operand-list reference model through a scoreboard.
module tb_pu_lut_arg_collector;

  logic        clk = 1'b0;
  logic        rst, wr, clr, rdy;
  logic [31:0] data;
  logic [3:0]  attr;

  logic [3:0] addr4, addr1;
  logic       v4, v1, inv4, inv1, err4, err1;

  always #5 clk = ~clk;

  pu_lut_arg_collector #(.ARG_COUNT(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_signal_wr(wr), .i_signal_clr(clr),
    .i_data_in(data), .i_attr_in(attr),
    .o_addr(addr4), .o_addr_valid(v4), .i_addr_ready(rdy),
    .o_addr_invalid(inv4), .o_err_overflow(err4)
  );

  pu_lut_arg_collector #(.ARG_COUNT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_signal_wr(wr), .i_signal_clr(clr),
    .i_data_in(data), .i_attr_in(attr),
    .o_addr(addr1), .o_addr_valid(v1), .i_addr_ready(rdy),
    .o_addr_invalid(inv1), .o_err_overflow(err1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state per collector (index 0: 4 operands, index 1: 1 operand).
  int       cnt  [2];
  int       acc  [2];
  bit       minv [2];
  bit       pend [2];
  bit       merr [2];
  int       last_hs [2];
  bit [4:0] q0[$];
  bit [4:0] q1[$];
  bit       started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit [4:0] qfront(input int m);
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int m, input bit [4:0] e);
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qpop(input int m);
    if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic clear_acc(input int m);
    cnt[m] = 0; acc[m] = 0; minv[m] = 1'b0;
  endtask

  // One clock edge of the specification's rules, applied to a list of collected operands.
  task automatic model_step(input int m, input int n);
    int op;
    bit oi;
    op = (data != 0) ? 1 : 0;
    oi = attr[0];
    if (rst) begin
      clear_acc(m);
      pend[m] = 1'b0;
      merr[m] = 1'b0;
      if (m == 0) q0.delete(); else q1.delete();
    end else if (pend[m]) begin
      if (rdy) begin
        pend[m] = 1'b0;
        clear_acc(m);
        if (wr) begin
          acc[m] = op; minv[m] = oi; cnt[m] = 1;
          if (cnt[m] == n) begin
            qpush(m, {minv[m], 4'(acc[m])});
            pend[m] = 1'b1;
          end
        end
      end else if (wr) begin
        merr[m] = 1'b1;
      end
    end else if (clr) begin
      clear_acc(m);
    end else if (wr) begin
      acc[m]  = acc[m] + (op << cnt[m]);
      minv[m] = minv[m] | oi;
      cnt[m]++;
      if (cnt[m] == n) begin
        qpush(m, {minv[m], 4'(acc[m])});
        pend[m] = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit w, input bit c, input bit r, input logic [31:0] d,
                       input logic [3:0] at, input bit rs = 1'b0);
    wr = w; clr = c; rdy = r; data = d; attr = at; rst = rs;
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 1);
    started = 1'b1;
    #1;
  endtask

  // Monitor: compares DUT outputs with the model and retires handshakes from the queues.
  task automatic mon(input int m, input logic [3:0] a, input logic v, input logic iv, input logic e);
    bit [4:0] exp;
    chk($sformatf("valid%0d", m), 32'(v), 32'(pend[m]));
    chk($sformatf("err%0d", m), 32'(e), 32'(merr[m]));
    if (pend[m]) begin
      if (qsize(m) == 0) begin
        total++; bad++;
        $display("FAIL scoreboard%0d: addr_valid=%0b with no expected address", m, v);
      end else begin
        exp = qfront(m);
        chk($sformatf("addr%0d", m), 32'(a), 32'(exp[3:0]));
        chk($sformatf("inv%0d", m), 32'(iv), 32'(exp[4]));
        if (rdy && !rst) begin
          last_hs[m] = {27'd0, iv, a};
          qpop(m);
        end
      end
    end else if (cnt[m] == 0) begin
      chk($sformatf("idle_addr%0d", m), 32'(a), 32'd0);
      chk($sformatf("idle_inv%0d", m), 32'(iv), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, addr4, v4, inv4, err4);
      mon(1, addr1, v1, inv1, err1);
    end
  end

  task automatic write4(input logic [31:0] a, b, c, d, input logic [3:0] ib = 4'd0);
    drive(1, 0, 0, a, 4'd0);
    drive(1, 0, 0, b, ib);
    drive(1, 0, 0, c, 4'd0);
    drive(1, 0, 0, d, 4'd0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      clear_acc(m); pend[m] = 0; merr[m] = 0; last_hs[m] = -1;
    end
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("reset_addr", 32'(addr4), 32'd0);
    chk("reset_valid", 32'(v4), 32'd0);
    chk("reset_inv", 32'(inv4), 32'd0);
    chk("reset_err", 32'(err4), 32'd0);

    // 1: basic packing
    write4(1, 0, 5, 0);
    drive(0, 0, 1, 0, 0);
    chk("t1_hs", last_hs[0], 32'h05);
    chk("t1_valid_drop", 32'(v4), 32'd0);

    // 2: invalid flag on second operand, then clean address
    write4(1, 0, 5, 0, 4'd1);
    drive(0, 0, 1, 0, 0);
    chk("t2_hs", last_hs[0], 32'h15);
    write4(0, 3, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("t2_next_hs", last_hs[0], 32'h02);

    // 3: backpressure with a dropped write
    write4(1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 9, 1);
    drive(0, 0, 0, 0, 0);
    chk("t3_hold", 32'(addr4), 32'h5);
    chk("t3_err", 32'(err4), 32'd1);
    drive(0, 0, 1, 0, 0);
    chk("t3_hs", last_hs[0], 32'h05);

    // 4: handshake and new write in the same cycle
    drive(0, 0, 0, 0, 0, 1);
    write4(1, 0, 1, 0);
    drive(1, 0, 1, 1, 0);
    chk("t4_hs", last_hs[0], 32'h05);
    chk("t4_addr", 32'(addr4), 32'h1);
    chk("t4_valid", 32'(v4), 32'd0);
    chk("t4_err", 32'(err4), 32'd0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("t4_next_hs", last_hs[0], 32'h01);

    // 5: clear wins over a simultaneous write
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 0, 1, 0);
    chk("t5_clr_addr", 32'(addr4), 32'd0);
    chk("t5_clr_valid", 32'(v4), 32'd0);
    write4(1, 1, 1, 1);
    drive(0, 0, 1, 0, 0);
    chk("t5_hs", last_hs[0], 32'h0F);

    // 6: reset mid-collection, then single-operand build
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("t6_addr", 32'(addr4), 32'd0);
    chk("t6_valid", 32'(v4), 32'd0);
    chk("t6_err", 32'(err4), 32'd0);
    chk("t6_addr1", 32'(addr1), 32'd0);
    drive(1, 0, 0, 7, 0);
    chk("t6_v1", 32'(v1), 32'd1);
    chk("t6_a1", 32'(addr1), 32'd1);
    drive(0, 0, 1, 0, 0);
    chk("t6_hs1", last_hs[1], 32'h01);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 3) != 0,
            ($urandom % 2) ? $urandom : 32'd0, 4'($urandom),
            ($urandom % 250) == 0);
    end

    // Drain anything still pending
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0);
    chk("drain_q0", qsize(0), 0);
    chk("drain_q1", qsize(1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pu_lut_arg_collector
